// File: rtl/mcpnr_timer_pkg.sv
// Shared definitions for the switch-driven timer blocks: the timer state encoding
// and the default counter width.
package mcpnr_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_timer_if.sv
// Switch-bank / light-bank connection of the down timer. The switch side drives
// the load value, start and pause levels. The light side shows the count, busy and done.
interface down_timer_if
  import mcpnr_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_val, start, pause,
    input  count, busy, done
  );

  modport slave (
    input  load_val, start, pause,
    output count, busy, done
  );

endinterface

// File: rtl/down_timer_rise_detect.sv
// Rising-edge detector for a switch level: one history flop plus an AND.
// The flop clears on reset, so a level already high after reset reads as a rise.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q_rise
);

  logic d_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg <= 1'b0;
    end else begin
      d_reg <= d;
    end
  end

  assign q_rise = d & ~d_reg;

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer: loads on a START rising edge, counts to zero
// one per clock (frozen while PAUSE is high), then latches DONE until re-armed.
module down_timer
  import mcpnr_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  down_timer_if.slave  bus
);

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             start_rise;

  rise_detect u_start_rise (
    .clk    (clk),
    .rst    (rst),
    .d      (bus.start),
    .q_rise (start_rise)
  );

  // A start edge reloads from any state, ahead of pause and the zero test.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else if (start_rise) begin
      state_reg <= RUN;
      count_reg <= bus.load_val;
      busy_reg  <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (bus.pause) begin
            state_reg <= PAUSED;
          end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
          end else begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        // Resuming takes one cycle with no decrement.
        PAUSED: begin
          if (!bus.pause) begin
            state_reg <= RUN;
          end
        end
        IDLE, DONE: begin
          state_reg <= state_reg;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count = count_reg;
  assign bus.busy  = busy_reg;
  assign bus.done  = done_reg;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer: each task drives switch levels and compares
// {count, busy, done} against hand-computed values one clock at a time.
module tb_down_timer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  down_timer_if #(.WIDTH(4)) bus ();

  down_timer #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] obs;
    logic [5:0] exp;
    rst = 1'b1; bus.start = 1'b1; bus.pause = 1'b0; bus.load_val = 4'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'd0, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got cnt/busy/done=%h required %h", i, obs, exp);
      end
      $display("reset cycle %0d: cnt=%0d busy=%b done=%b", i, bus.count, bus.busy, bus.done);
    end
    // Release with START still high: counts as a rise, loads 7.
    rst = 1'b0;
    tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd7, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_release_load: got %h required %h", obs, exp);
    end
    for (int k = 6; k >= 0; k--) begin
      tick();
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'(k), 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset_release_count[%0d]: got %h required %h", k, obs, exp);
      end
    end
    tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd0, 1'b0, 1'b1};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_release_done: got %h required %h", obs, exp);
    end
    $display("test_reset: release load of 7 ran to done=%b", bus.done);
  endtask

  task automatic test_load3();
    logic [5:0] obs;
    logic [5:0] exp;
    bus.start = 1'b0; bus.load_val = 4'd3;
    tick();
    bus.start = 1'b1;
    tick();
    for (int k = 3; k >= 0; k--) begin
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'(k), 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL load3_count[%0d]: got %h required %h", k, obs, exp);
      end
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'd0, 1'b0, 1'b1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL load3_done_hold[%0d]: got %h required %h", i, obs, exp);
      end
      tick();
    end
    $display("test_load3: counted 3..0, done held, done=%b busy=%b", bus.done, bus.busy);
  endtask

  task automatic test_load0();
    logic [5:0] obs;
    logic [5:0] exp;
    bus.start = 1'b0; bus.load_val = 4'd0;
    tick();
    bus.start = 1'b1;
    tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd0, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL load0_busy: got %h required %h", obs, exp);
    end
    tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd0, 1'b0, 1'b1};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL load0_done: got %h required %h", obs, exp);
    end
    $display("test_load0: zero load reached done=%b", bus.done);
  endtask

  task automatic test_pause();
    logic [5:0] obs;
    logic [5:0] exp;
    bus.start = 1'b0; bus.load_val = 4'd15;
    tick();
    bus.start = 1'b1;
    tick();
    bus.load_val = 4'd2;  // changes after load must be ignored
    for (int i = 0; i < 6; i++) tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd9, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL pause_reach9: got %h required %h", obs, exp);
    end
    bus.pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'd9, 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL pause_hold[%0d]: got %h required %h", i, obs, exp);
      end
    end
    bus.pause = 1'b0;
    tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd9, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL pause_resume_cycle: got %h required %h", obs, exp);
    end
    for (int k = 8; k >= 0; k--) begin
      tick();
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'(k), 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL pause_countdown[%0d]: got %h required %h", k, obs, exp);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'd0, 1'b0, 1'b1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL pause_no_wrap[%0d]: got %h required %h", i, obs, exp);
      end
    end
    $display("test_pause: paused at 9, resumed, finished cnt=%0d", bus.count);
  endtask

  task automatic test_restart();
    logic [5:0] obs;
    logic [5:0] exp;
    bus.start = 1'b0; bus.load_val = 4'd10;
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd4, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL restart_reach4: got %h required %h", obs, exp);
    end
    bus.start = 1'b1; bus.load_val = 4'd2;
    for (int k = 2; k >= 0; k--) begin
      tick();
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'(k), 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL restart_count[%0d]: got %h required %h", k, obs, exp);
      end
    end
    tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd0, 1'b0, 1'b1};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL restart_done: got %h required %h", obs, exp);
    end
    // Rise while PAUSE is high: reload into RUN, then PAUSED on the next edge.
    bus.start = 1'b0;
    tick();
    bus.pause = 1'b1; bus.start = 1'b1; bus.load_val = 4'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'd6, 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL restart_paused_load[%0d]: got %h required %h", i, obs, exp);
      end
    end
    bus.pause = 1'b0; bus.start = 1'b0;
    tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd6, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL restart_paused_resume: got %h required %h", obs, exp);
    end
    tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd5, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL restart_paused_decrement: got %h required %h", obs, exp);
    end
    $display("test_restart: reload mid-run and under pause, cnt=%0d", bus.count);
  endtask

  task automatic test_reset_mid();
    logic [5:0] obs;
    logic [5:0] exp;
    bus.start = 1'b0; bus.load_val = 4'd8;
    tick();
    bus.start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd5, 1'b1, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL midreset_reach5: got %h required %h", obs, exp);
    end
    rst = 1'b1;
    tick();
    obs = {bus.count, bus.busy, bus.done};
    exp = {4'd0, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL midreset_idle: got %h required %h", obs, exp);
    end
    // START still high at release: exactly one load, then no re-trigger.
    rst = 1'b0; bus.load_val = 4'd2;
    for (int k = 2; k >= 0; k--) begin
      tick();
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'(k), 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL midreset_reload[%0d]: got %h required %h", k, obs, exp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'd0, 1'b0, 1'b1};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL midreset_no_retrigger[%0d]: got %h required %h", i, obs, exp);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      obs = {bus.count, bus.busy, bus.done};
      exp = {4'd0, 1'b0, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL done_reset_idle[%0d]: got %h required %h", i, obs, exp);
      end
    end
    $display("test_reset_mid: reset mid-count and in done, busy=%b done=%b", bus.busy, bus.done);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; bus.start = 1'b0; bus.pause = 1'b0; bus.load_val = 4'd0;
    test_reset();
    test_load3();
    test_load0();
    test_pause();
    test_restart();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
